// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of mem_arbiter.
// The arbiter connects through the slave modport; requesters and memory
// (or a bench) drive through the master modport.
interface mem_arbiter_if #(
    parameter int NPORTS = 3,
    parameter int AW     = 22,
    parameter int DW     = 32
);
    logic [NPORTS-1:0]    port_req;
    logic [NPORTS-1:0]    port_write;
    logic [NPORTS*AW-1:0] port_addr;
    logic [NPORTS*DW-1:0] port_wdata;
    logic [NPORTS-1:0]    port_ready;
    logic [NPORTS-1:0]    port_done;
    logic [DW-1:0]        port_rdata;
    logic                 port_err;

    logic                 mem_req;
    logic                 mem_write;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ready;
    logic                 mem_done;
    logic [DW-1:0]        mem_rdata;

    modport slave (
        input  port_req, port_write, port_addr, port_wdata,
        output port_ready, port_done, port_rdata, port_err,
        output mem_req, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_done, mem_rdata
    );

    modport master (
        output port_req, port_write, port_addr, port_wdata,
        input  port_ready, port_done, port_rdata, port_err,
        input  mem_req, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-port to single-memory arbiter, one transaction in flight.
// Round-robin or fixed-priority grant, optional WAIT timeout with error flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; grants a requester unless a completion pulse
//        | is being presented this cycle (lets the served port drop req)
// ISSUE  | mem_req high with latched write/addr/wdata until mem_ready
// WAIT   | accepted downstream; waiting for mem_done or timeout
module mem_arbiter #(
    parameter int NPORTS  = 3,
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cmpl_q, cmpl_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [NPORTS-1:0] port_ready_q, port_ready_d;
    logic [NPORTS-1:0] port_done_q, port_done_d;
    logic [DW-1:0]     port_rdata_q, port_rdata_d;
    logic              port_err_q, port_err_d;

    logic              sel_found;
    logic [GW-1:0]     sel_idx;
    logic [NPORTS-1:0] grant_oh;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int off);
        int s;
        s = int'(last) + off;
        if (s >= NPORTS) s = s - NPORTS;
        return GW'(s);
    endfunction

    assign grant_oh = NPORTS'(1) << grant_q;

    // Pick the next port: circular search after last grant, or lowest index wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (RR != 0) begin
            for (int off = 1; off <= NPORTS; off++) begin
                if (!sel_found && bus.port_req[rr_idx(last_grant_q, off)]) begin
                    sel_found = 1'b1;
                    sel_idx   = rr_idx(last_grant_q, off);
                end
            end
        end else begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (bus.port_req[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = GW'(i);
                end
            end
        end
    end

    // Transaction sequencing and registered output values
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        cmpl_d       = 1'b0;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        port_ready_d = '0;
        port_done_d  = '0;
        port_rdata_d = port_rdata_q;
        port_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_found && !cmpl_q) begin
                    grant_d      = sel_idx;
                    last_grant_d = sel_idx;
                    mem_req_d    = 1'b1;
                    mem_write_d  = bus.port_write[sel_idx];
                    mem_addr_d   = bus.port_addr[int'(sel_idx) * AW +: AW];
                    mem_wdata_d  = bus.port_wdata[int'(sel_idx) * DW +: DW];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ready) begin
                    mem_req_d    = 1'b0;
                    port_ready_d = grant_oh;
                    cnt_d        = '0;
                    if (bus.mem_done) begin
                        port_done_d  = grant_oh;
                        port_rdata_d = bus.mem_rdata;
                        cmpl_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_done) begin
                    port_done_d  = grant_oh;
                    port_rdata_d = bus.mem_rdata;
                    cmpl_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    port_done_d  = grant_oh;
                    port_err_d   = 1'b1;
                    port_rdata_d = '1;
                    cmpl_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NPORTS - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            cmpl_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            port_ready_q <= '0;
            port_done_q  <= '0;
            port_rdata_q <= '0;
            port_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            cmpl_q       <= cmpl_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            port_ready_q <= port_ready_d;
            port_done_q  <= port_done_d;
            port_rdata_q <= port_rdata_d;
            port_err_q   <= port_err_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.port_ready = port_ready_q;
    assign bus.port_done  = port_done_q;
    assign bus.port_rdata = port_rdata_q;
    assign bus.port_err   = port_err_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3, number of requesting ports (2..8).
REQ-002 SHALL have parameter AW, default 22, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter RR, default 1: 1 = round-robin grant, 0 = fixed priority (port 0 highest).
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles in WAIT before abort (0 = disabled); counter width = clog2(TIMEOUT+1).
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port port_req, input, NPORTS, per-port request, held until port_ready.
REQ-009 SHALL have port port_write, input, NPORTS, per-port write qualifier.
REQ-010 SHALL have port port_addr, input, NPORTS*AW, flattened addresses; port i at [i*AW +: AW].
REQ-011 SHALL have port port_wdata, input, NPORTS*DW, flattened write data; port i at [i*DW +: DW].
REQ-012 SHALL have port port_ready, output, NPORTS, one-cycle accept pulse to the granted port.
REQ-013 SHALL have port port_done, output, NPORTS, one-cycle completion pulse to the granted port.
REQ-014 SHALL have port port_rdata, output, DW, shared read data, valid in the port_done cycle and held until the next completion.
REQ-015 SHALL have port port_err, output, 1, high with port_done when the transaction timed out.
REQ-016 SHALL have port mem_req, mem_write, output, 1 each, downstream request and write qualifier.
REQ-017 SHALL have port mem_addr, output, AW, and mem_wdata, output, DW, downstream address and write data.
REQ-018 SHALL have port mem_ready, input, 1, downstream accept; mem_done, input, 1, downstream completion; mem_rdata, input, DW.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT; exactly one transaction in flight.
REQ-020 IDLE: if any port_req bit is set, SHALL select grant g, latch port_write/addr/wdata of g, and enter ISSUE next cycle; otherwise stay in IDLE.
REQ-021 RR=1: SHALL search from (last_grant+1) mod NPORTS upward circularly; last_grant updates on every grant; last_grant resets to NPORTS-1, so port 0 wins first.
REQ-022 RR=0: SHALL grant the lowest-numbered requesting port.
REQ-023 ISSUE: mem_req SHALL be 1 with the latched write/addr/wdata; mem_addr and mem_wdata are stable for the whole ISSUE period.
REQ-024 ISSUE with mem_ready=1: port_ready[g] SHALL pulse the next cycle, mem_req SHALL drop the next cycle, and the state SHALL enter WAIT.
REQ-025 ISSUE with mem_ready=1 and mem_done=1 in the same cycle: the transaction SHALL complete; port_ready[g] and port_done[g] pulse together next cycle, then return to IDLE.
REQ-026 WAIT with mem_done=1: SHALL register mem_rdata into port_rdata, pulse port_done[g] with port_err=0 next cycle, and return to IDLE.
REQ-027 WAIT: a counter SHALL increment each cycle; at TIMEOUT, SHALL pulse port_done[g] with port_err=1, set port_rdata to all ones, and return to IDLE; a later stray mem_done is ignored while in IDLE.
REQ-028 Write transactions SHALL also pulse port_done; port_rdata SHALL then take mem_rdata as presented.
REQ-029 Deassertion of port_req[g] after grant SHALL NOT cancel the transaction; a request dropped before grant is never served.
REQ-030 Back-to-back: the earliest new grant SHALL be in the IDLE cycle following completion, giving a minimum 3-cycle spacing per transaction.
REQ-031 RR fairness: SHALL serve any continuously requesting port within NPORTS grants.
REQ-032 At most one bit of port_ready and of port_done SHALL be high in any cycle.

Reset
REQ-033 On reset assertion, at any time including mid-transaction, SHALL immediately enter IDLE with mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, port_ready=0, port_done=0, port_err=0, port_rdata=0, last_grant=NPORTS-1, timeout counter=0; the in-flight transaction is dropped without port_done.

Verification
REQ-034 SHALL verify single read: NPORTS=3, port1 requests addr 0x00123, mem_ready 2 cycles later, mem_done with 0xDEADBEEF 4 cycles later -> mem_addr=0x00123, mem_write=0, port_ready[1] pulse, port_done[1] pulse, port_rdata=0xDEADBEEF, port_err=0.
REQ-035 SHALL verify round-robin: ports 0,1,2 request continuously with RR=1 -> grant order 0,1,2,0,1,2; with RR=0 -> all grants go to port 0.
REQ-036 SHALL verify same-cycle completion: mem_ready and mem_done both high in the first ISSUE cycle -> port_ready and port_done pulse in the same cycle, back in IDLE one cycle later.
REQ-037 SHALL verify timeout: TIMEOUT=8 and mem_done never arrives -> port_done[g]=1 and port_err=1 exactly 8 cycles after entering WAIT, port_rdata=0xFFFFFFFF; a late mem_done produces no pulse.
REQ-038 SHALL verify mid-transaction reset: reset asserted in WAIT -> all outputs 0 with no port_done; after release, port 0 is granted first.
